// File: rtl/tdma_job_launcher_if.sv
// Job descriptor, register-bus and completion signals of the TDMA job launcher.
// master = launcher side (drives the register bus), slave = environment side.
interface tdma_job_launcher_if;
  logic        job_valid_i, job_ready_o;
  logic [63:0] job_src_i, job_dst_i, job_len_i;
  logic [2:0]  job_conf_i;
  logic        reg_valid_o, reg_write_o;
  logic [7:0]  reg_wstrb_o;
  logic [63:0] reg_addr_o, reg_wdata_o;
  logic        reg_ready_i, reg_error_i;
  logic [63:0] reg_rdata_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [63:0] rsp_id_o;
  logic        rsp_err_o;
  logic        busy_o;

  modport master (
    input  job_valid_i, job_src_i, job_dst_i, job_len_i, job_conf_i,
           reg_ready_i, reg_error_i, reg_rdata_i, rsp_ready_i,
    output job_ready_o, reg_valid_o, reg_write_o, reg_wstrb_o, reg_addr_o,
           reg_wdata_o, rsp_valid_o, rsp_id_o, rsp_err_o, busy_o
  );

  modport slave (
    output job_valid_i, job_src_i, job_dst_i, job_len_i, job_conf_i,
           reg_ready_i, reg_error_i, reg_rdata_i, rsp_ready_i,
    input  job_ready_o, reg_valid_o, reg_write_o, reg_wstrb_o, reg_addr_o,
           reg_wdata_o, rsp_valid_o, rsp_id_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/tdma_job_launcher.sv
// Takes a DMA job descriptor, programs the tdma config registers over the
// register bus, launches it by reading NEXT_ID and returns the ID/error.
module tdma_job_launcher #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned TIMEOUT   = 1024
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  tdma_job_launcher_if.master bus
);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [63:0] OFS_SRC  = 64'h00;
  localparam logic [63:0] OFS_DST  = 64'h08;
  localparam logic [63:0] OFS_LEN  = 64'h10;
  localparam logic [63:0] OFS_CONF = 64'h18;
  localparam logic [63:0] OFS_ID   = 64'h28;

  typedef enum logic [2:0] {IDLE, WR_SRC, WR_DST, WR_LEN, WR_CONF, RD_ID, RESP} state_e;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [63:0] len;
    logic [2:0]  conf;
  } desc_t;

  state_e        state_q, state_d;
  desc_t         desc_q;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic [63:0]   rsp_id_q;
  logic          rsp_err_q;
  logic          accept, req_done, stall, timeout;

  assign accept   = (state_q == IDLE) && bus.job_valid_i;
  assign req_done = bus.reg_valid_o && bus.reg_ready_i;
  assign stall    = bus.reg_valid_o && !bus.reg_ready_i;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  // Abort on the edge that ends the TIMEOUT-th stalled cycle, so reg_valid_o
  // is gone the very next cycle.
  assign timeout  = (TIMEOUT != 0) && stall && (cnt_inc == CW'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.job_valid_i) state_d = (bus.job_len_i == '0) ? RESP : WR_SRC;
      WR_SRC:  if (req_done) state_d = bus.reg_error_i ? RESP : WR_DST;
               else if (timeout) state_d = RESP;
      WR_DST:  if (req_done) state_d = bus.reg_error_i ? RESP : WR_LEN;
               else if (timeout) state_d = RESP;
      WR_LEN:  if (req_done) state_d = bus.reg_error_i ? RESP : WR_CONF;
               else if (timeout) state_d = RESP;
      WR_CONF: if (req_done) state_d = bus.reg_error_i ? RESP : RD_ID;
               else if (timeout) state_d = RESP;
      RD_ID:   if (req_done || timeout) state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.job_ready_o = (state_q == IDLE);
    bus.busy_o      = (state_q != IDLE);
    bus.rsp_valid_o = (state_q == RESP);
    bus.rsp_id_o    = rsp_id_q;
    bus.rsp_err_o   = rsp_err_q;
    bus.reg_valid_o = 1'b0;
    bus.reg_write_o = 1'b0;
    bus.reg_wstrb_o = 8'h00;
    bus.reg_addr_o  = '0;
    bus.reg_wdata_o = '0;
    if (state_q inside {WR_SRC, WR_DST, WR_LEN, WR_CONF}) begin
      bus.reg_valid_o = 1'b1;
      bus.reg_write_o = 1'b1;
      bus.reg_wstrb_o = 8'hFF;
    end
    case (state_q)
      WR_SRC:  begin bus.reg_addr_o = BASE_ADDR + OFS_SRC;  bus.reg_wdata_o = desc_q.src; end
      WR_DST:  begin bus.reg_addr_o = BASE_ADDR + OFS_DST;  bus.reg_wdata_o = desc_q.dst; end
      WR_LEN:  begin bus.reg_addr_o = BASE_ADDR + OFS_LEN;  bus.reg_wdata_o = desc_q.len; end
      WR_CONF: begin bus.reg_addr_o = BASE_ADDR + OFS_CONF; bus.reg_wdata_o = {61'b0, desc_q.conf}; end
      RD_ID:   begin bus.reg_addr_o = BASE_ADDR + OFS_ID;   bus.reg_valid_o = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      desc_q    <= '0;
      cnt_q     <= '0;
      rsp_id_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_d != state_q) cnt_q <= '0;
      else if (stall)         cnt_q <= cnt_inc;
      if (accept) begin
        desc_q    <= '{bus.job_src_i, bus.job_dst_i, bus.job_len_i, bus.job_conf_i};
        rsp_id_q  <= '0;
        rsp_err_q <= (bus.job_len_i == '0);
      end else if (state_q == RD_ID && req_done) begin
        rsp_id_q  <= bus.reg_rdata_i;
        rsp_err_q <= bus.reg_error_i;
      end else if (timeout || (req_done && bus.reg_error_i)) begin
        rsp_id_q  <= '0;
        rsp_err_q <= 1'b1;
      end
    end
  end
endmodule

// File: doc/tdma_job_launcher.md
TDMA_JOB_LAUNCHER -- requirements
Module: tdma_job_launcher

Interface
REQ-001 Parameter BASE_ADDR, default 64'h0: register-bus base address of the tdma config block.
REQ-002 Parameter TIMEOUT, default 1024: max cycles waiting on reg_ready_i per transaction; 0 disables the timeout.
REQ-003 clk_i  in  1  clock; all state on rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 job_valid_i / job_ready_o  in/out  1 each  job descriptor handshake.
REQ-006 job_src_i, job_dst_i, job_len_i  in  64 each  source address, destination address, byte count.
REQ-007 job_conf_i  in  3  {serialize, deburst, decouple}, written to CONF bits [2:0].
REQ-008 reg_valid_o, reg_write_o  out  1 each; reg_wstrb_o  out  8; reg_addr_o, reg_wdata_o  out  64  register-bus master request.
REQ-009 reg_ready_i, reg_error_i  in  1 each; reg_rdata_i  in  64  register-bus response, valid in the reg_valid_o && reg_ready_i cycle.
REQ-010 rsp_valid_o / rsp_ready_i  out/in  1 each  completion handshake.
REQ-011 rsp_id_o  out  64  transfer ID; rsp_err_o  out  1  job failed.
REQ-012 busy_o  out  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, WR_SRC, WR_DST, WR_LEN, WR_CONF, RD_ID, RESP.
REQ-014 Register offsets from BASE_ADDR: SRC 0x00, DST 0x08, NUM_BYTES 0x10, CONF 0x18, NEXT_ID 0x28.
REQ-015 job_ready_o = 1 only in IDLE; descriptor captured into internal registers on job_valid_i && job_ready_o.
REQ-016 On accept with job_len_i != 0: next state WR_SRC; the first reg_valid_o appears the cycle after accept.
REQ-017 On accept with job_len_i == 0: go directly to RESP with rsp_err_o = 1 and rsp_id_o = 0; no bus transaction issued.
REQ-018 In WR_* states: reg_valid_o = 1, reg_write_o = 1, reg_wstrb_o = 8'hFF; reg_wdata_o = the latched field; CONF wdata = {61'b0, conf}.
REQ-019 In RD_ID: reg_valid_o = 1, reg_write_o = 0, reg_wstrb_o = 8'h00, reg_wdata_o = 0; this read launches the transfer.
REQ-020 Request fields held stable while reg_valid_o = 1 and reg_ready_i = 0.
REQ-021 Transaction completes in the cycle reg_valid_o && reg_ready_i; the FSM advances WR_SRC->WR_DST->WR_LEN->WR_CONF->RD_ID->RESP, one state per completion.
REQ-022 Back-to-back: with reg_ready_i tied high, a job takes exactly 5 bus cycles, and RESP is entered on cycle 6 after accept.
REQ-023 On completion of RD_ID: rsp_id_o <= reg_rdata_i, rsp_err_o <= reg_error_i.
REQ-024 reg_error_i = 1 at completion of any WR_* state: skip the remaining states, go to RESP with rsp_err_o = 1, rsp_id_o = 0.
REQ-025 A per-transaction wait counter resets on every state entry and increments while reg_valid_o && !reg_ready_i.
REQ-026 Counter reaching TIMEOUT (TIMEOUT != 0): deassert reg_valid_o the next cycle, go to RESP with rsp_err_o = 1, rsp_id_o = 0.
REQ-027 Counter saturates; counter width = $clog2(TIMEOUT+1), minimum 1.
REQ-028 RESP: rsp_valid_o = 1, rsp_id_o and rsp_err_o stable until rsp_ready_i; on rsp_valid_o && rsp_ready_i return to IDLE.
REQ-029 job_ready_o is 0 in the RESP handshake cycle; a new job is accepted no earlier than the cycle after the return to IDLE.
REQ-030 reg_valid_o and rsp_valid_o are never high in the same cycle.

Reset
REQ-031 On rst_ni = 0, asynchronously: state IDLE; the following outputs reset to 0: reg_valid_o, reg_write_o, reg_wstrb_o, reg_addr_o, reg_wdata_o, rsp_valid_o, rsp_id_o, rsp_err_o, busy_o. Wait counter and descriptor registers also clear to 0.
REQ-032 job_ready_o = 1 from the first cycle after rst_ni deasserts.
REQ-033 Reset mid-job (any state) discards the job with no response; the bus request drops immediately.

Verification
REQ-034 Test: src=0x1000, dst=0x2000, len=0x40, conf=3'b001, ready always high, rdata=0x7 on RD_ID. Required: writes to 0x00/0x08/0x10/0x18 with values 0x1000/0x2000/0x40/0x1; read of 0x28; rsp_id_o=0x7, rsp_err_o=0.
REQ-035 Test: same job, reg_ready_i low for 3 cycles on WR_DST. Required: addr=0x08 and wdata=0x2000 held for 4 cycles; no other changes.
REQ-036 Test: reg_error_i=1 on the WR_LEN completion. Required: no CONF write and no NEXT_ID read; rsp_err_o=1, rsp_id_o=0.
REQ-037 Test: TIMEOUT=4, reg_ready_i held low. Required: reg_valid_o drops after 4 wait cycles; rsp_err_o=1.
REQ-038 Test: len=0. Required: no reg_valid_o ever asserted; rsp_valid_o the cycle after accept with rsp_err_o=1.
REQ-039 Test: rsp_ready_i low for 5 cycles, then rst_ni pulsed during a second job's WR_SRC. Required: response held stable for the 5 cycles; after reset all outputs 0 and job_ready_o=1.
